// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// fsm_state mirrors the converter's state register (0 = IDLE, 1 = SHIFT).
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start_in;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy_out;
  logic                  done_out;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow_out;
  logic [DIGITS-1:0]     lz_out;
  logic                  fsm_state;

  modport master (
    output start_in, bin_in,
    input  busy_out, done_out, bcd_out, overflow_out, lz_out, fsm_state
  );

  modport slave (
    input  start_in, bin_in,
    output busy_out, done_out, bcd_out, overflow_out, lz_out, fsm_state
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with overflow and leading-zero flags registered alongside the digits.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  bin_to_bcd_seq_if.slave  bus
);

  // Handshake: start_in acts as valid and ~busy_out as ready; a request is
  // taken on any rising edge where both hold, bin_in is sampled only on that
  // edge, and done_out pulses for one cycle on the edge the results change.

  function automatic longint unsigned pow10(input int d);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  localparam int CW       = $clog2(WIDTH + 1);
  localparam int POW_W    = $clog2(pow10(DIGITS)) + 1;
  localparam int CMP_W    = (WIDTH > POW_W) ? WIDTH : POW_W;
  localparam int BW       = 4 * DIGITS;
  localparam logic [CMP_W-1:0]  LIMIT    = CMP_W'(pow10(DIGITS));
  localparam logic [DIGITS-1:0] LZ_RESET = ~DIGITS'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_cap_q, ovf_cap_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              overflow_q, overflow_d;
  logic [DIGITS-1:0] lz_q, lz_d;
  logic              done_q, done_d;
  logic [BW-1:0]     adj;
  logic [CMP_W-1:0]  bin_ext;

  // Digit i is flagged when it and every digit above it are zero; the ones
  // digit is never flagged so a display always shows at least one digit.
  function automatic logic [DIGITS-1:0] lz_of(input logic [BW-1:0] d);
    logic [DIGITS-1:0] r;
    logic              zero_above;
    r          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (d[4*i +: 4] == 4'd0);
      r[i]       = zero_above;
    end
    return r;
  endfunction

  assign bin_ext = CMP_W'(bus.bin_in);

  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_cap_d  = ovf_cap_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    lz_d       = lz_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          shift_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          ovf_cap_d = (bin_ext >= LIMIT);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Bits leaving the top digit are dropped, giving value mod 10^DIGITS.
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          bcd_d      = scratch_d;
          overflow_d = ovf_cap_q;
          lz_d       = lz_of(scratch_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_cap_q  <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      lz_q       <= LZ_RESET;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_cap_q  <= ovf_cap_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      lz_q       <= lz_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy_out     = (state_q == SHIFT);
  assign bus.done_out     = done_q;
  assign bus.bcd_out      = bcd_q;
  assign bus.overflow_out = overflow_q;
  assign bus.lz_out       = lz_q;
  assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: four configurations driven together, checked each
// cycle against an arithmetic model plus directed literal expectations.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if0 ();
  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) if1 ();
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if2 ();
  bin_to_bcd_seq_if #(.WIDTH(1),  .DIGITS(1)) if3 ();

  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3)) u0 (.clk_in(clk), .rst_n_in(rst_n), .bus(if0));
  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(2)) u1 (.clk_in(clk), .rst_n_in(rst_n), .bus(if1));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u2 (.clk_in(clk), .rst_n_in(rst_n), .bus(if2));
  bin_to_bcd_seq #(.WIDTH(1),  .DIGITS(1)) u3 (.clk_in(clk), .rst_n_in(rst_n), .bus(if3));

  logic        drv_start[4];
  logic [31:0] drv_bin[4];
  logic        dut_busy[4];
  logic        dut_done[4];
  logic        dut_ovf[4];
  logic [39:0] dut_bcd[4];
  logic [9:0]  dut_lz[4];

  assign if0.start_in = drv_start[0];
  assign if1.start_in = drv_start[1];
  assign if2.start_in = drv_start[2];
  assign if3.start_in = drv_start[3];
  assign if0.bin_in = drv_bin[0][7:0];
  assign if1.bin_in = drv_bin[1][7:0];
  assign if2.bin_in = drv_bin[2][15:0];
  assign if3.bin_in = drv_bin[3][0:0];

  assign dut_busy[0] = if0.busy_out;  assign dut_done[0] = if0.done_out;
  assign dut_busy[1] = if1.busy_out;  assign dut_done[1] = if1.done_out;
  assign dut_busy[2] = if2.busy_out;  assign dut_done[2] = if2.done_out;
  assign dut_busy[3] = if3.busy_out;  assign dut_done[3] = if3.done_out;
  assign dut_ovf[0] = if0.overflow_out;
  assign dut_ovf[1] = if1.overflow_out;
  assign dut_ovf[2] = if2.overflow_out;
  assign dut_ovf[3] = if3.overflow_out;
  assign dut_bcd[0] = 40'(if0.bcd_out);
  assign dut_bcd[1] = 40'(if1.bcd_out);
  assign dut_bcd[2] = 40'(if2.bcd_out);
  assign dut_bcd[3] = 40'(if3.bcd_out);
  assign dut_lz[0] = 10'(if0.lz_out);
  assign dut_lz[1] = 10'(if1.lz_out);
  assign dut_lz[2] = 10'(if2.lz_out);
  assign dut_lz[3] = 10'(if3.lz_out);

  function automatic int w_of(input int i);
    case (i)
      0: return 8;
      1: return 8;
      2: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int d_of(input int i);
    case (i)
      0: return 3;
      1: return 2;
      2: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic longint unsigned p10(input int d);
    longint unsigned r = 1;
    for (int k = 0; k < d; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [39:0] exp_bcd(input longint unsigned v, input int d);
    logic [39:0] r = '0;
    longint unsigned m = v % p10(d);
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Digits i.. top are all zero exactly when the kept value is below 10^i.
  function automatic logic [9:0] exp_lz(input longint unsigned v, input int d);
    logic [9:0] r = '0;
    longint unsigned m = v % p10(d);
    for (int i = 1; i < d; i++) r[i] = (m < p10(i));
    return r;
  endfunction

  // Behavioural model: transaction timing plus arithmetic results.
  bit              m_busy[4];
  bit              m_done[4];
  int              m_cnt[4];
  logic [39:0]     m_bcd[4];
  bit              m_ovf[4];
  logic [9:0]      m_lz[4];
  longint unsigned m_val[4];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_bcd[i]  <= '0;
        m_ovf[i]  <= 1'b0;
        m_lz[i]   <= exp_lz(0, d_of(i));
        m_val[i]  <= 0;
      end else if (m_busy[i]) begin
        if (m_cnt[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_bcd[i]  <= exp_bcd(m_val[i], d_of(i));
          m_ovf[i]  <= (m_val[i] >= p10(d_of(i)));
          m_lz[i]   <= exp_lz(m_val[i], d_of(i));
        end else begin
          m_cnt[i]  <= m_cnt[i] - 1;
          m_done[i] <= 1'b0;
        end
      end else begin
        m_done[i] <= 1'b0;
        if (drv_start[i]) begin
          m_busy[i] <= 1'b1;
          m_cnt[i]  <= w_of(i);
          m_val[i]  <= longint'(drv_bin[i]) & ((64'd1 << w_of(i)) - 64'd1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("u%0d.busy", i), 64'(dut_busy[i]), 64'(m_busy[i]));
        chk($sformatf("u%0d.done", i), 64'(dut_done[i]), 64'(m_done[i]));
        chk($sformatf("u%0d.bcd", i), 64'(dut_bcd[i]), 64'(m_bcd[i]));
        chk($sformatf("u%0d.ovf", i), 64'(dut_ovf[i]), 64'(m_ovf[i]));
        chk($sformatf("u%0d.lz", i), 64'(dut_lz[i]), 64'(m_lz[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion on instance i from an idle DUT; lat counts edges from the
  // accepting edge to the done edge (64 means no done was seen).
  task automatic run_conv(input int i, input logic [31:0] val, output int lat,
                          output logic [39:0] bcd, output logic ovf, output logic [9:0] lz);
    drv_start[i] = 1'b1;
    drv_bin[i]   = val;
    tick();
    drv_start[i] = 1'b0;
    drv_bin[i]   = $urandom;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!dut_done[i] && lat < 64);
    bcd = dut_bcd[i];
    ovf = dut_ovf[i];
    lz  = dut_lz[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  int          lat, n_done, gap;
  logic [39:0] bcd;
  logic        ovf;
  logic [9:0]  lz;
  int          tab_v[8]     = '{9, 10, 79, 80, 81, 255, 0, 100};
  logic [39:0] tab_bcd[8]   = '{40'h009, 40'h010, 40'h079, 40'h080, 40'h081, 40'h255, 40'h000, 40'h100};
  logic [9:0]  tab_lz[8]    = '{10'b110, 10'b100, 10'b100, 10'b100, 10'b100, 10'b000, 10'b110, 10'b000};

  initial begin
    for (int i = 0; i < 4; i++) begin
      drv_start[i] = 1'b0;
      drv_bin[i]   = '0;
    end

    // Model pins against hand-computed digits.
    chk("model.bcd255_3", 64'(exp_bcd(255, 3)), 64'h255);
    chk("model.bcd255_2", 64'(exp_bcd(255, 2)), 64'h55);
    chk("model.lz10_3", 64'(exp_lz(10, 3)), 64'b100);
    chk("model.bcd65535", 64'(exp_bcd(65535, 5)), 64'h65535);

    #12;
    chk("reset.busy", 64'(dut_busy[0]), 64'd0);
    chk("reset.done", 64'(dut_done[0]), 64'd0);
    chk("reset.bcd", 64'(dut_bcd[0]), 64'd0);
    chk("reset.ovf", 64'(dut_ovf[0]), 64'd0);
    chk("reset.lz0", 64'(dut_lz[0]), 64'b110);
    chk("reset.lz1", 64'(dut_lz[1]), 64'b10);
    chk("reset.lz3", 64'(dut_lz[3]), 64'b0);
    #10;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // Full sweep on the 8-bit, 3-digit instance.
    for (int v = 0; v < 256; v++) begin
      run_conv(0, 32'(v), lat, bcd, ovf, lz);
      chk("sweep.latency", 64'(lat), 64'd8);
      chk("sweep.ovf", 64'(ovf), 64'd0);
    end
    for (int t = 0; t < 8; t++) begin
      run_conv(0, 32'(tab_v[t]), lat, bcd, ovf, lz);
      chk($sformatf("table.bcd[%0d]", tab_v[t]), 64'(bcd), 64'(tab_bcd[t]));
      chk($sformatf("table.lz[%0d]", tab_v[t]), 64'(lz), 64'(tab_lz[t]));
    end

    // Two-digit instance: overflow boundary.
    run_conv(1, 32'd99, lat, bcd, ovf, lz);
    chk("d2.99.bcd", 64'(bcd), 64'h99);
    chk("d2.99.ovf", 64'(ovf), 64'd0);
    run_conv(1, 32'd100, lat, bcd, ovf, lz);
    chk("d2.100.bcd", 64'(bcd), 64'h00);
    chk("d2.100.ovf", 64'(ovf), 64'd1);
    chk("d2.100.lz", 64'(lz), 64'b10);
    run_conv(1, 32'd255, lat, bcd, ovf, lz);
    chk("d2.255.bcd", 64'(bcd), 64'h55);
    chk("d2.255.ovf", 64'(ovf), 64'd1);

    // Wide and one-bit instances.
    run_conv(2, 32'd65535, lat, bcd, ovf, lz);
    chk("w16.bcd", 64'(bcd), 64'h65535);
    chk("w16.latency", 64'(lat), 64'd16);
    chk("w16.ovf", 64'(ovf), 64'd0);
    run_conv(3, 32'd1, lat, bcd, ovf, lz);
    chk("w1.bcd", 64'(bcd), 64'h1);
    chk("w1.latency", 64'(lat), 64'd1);
    for (int t = 0; t < 20; t++) begin
      run_conv(2, 32'($urandom_range(0, 65535)), lat, bcd, ovf, lz);
      chk("w16.rand.latency", 64'(lat), 64'd16);
    end

    // Requests while busy are dropped.
    drv_start[0] = 1'b1;
    drv_bin[0]   = 32'd42;
    tick();
    drv_bin[0] = 32'd200;
    n_done = 0;
    for (int c = 0; c < 7; c++) tick();
    drv_start[0] = 1'b0;
    bcd = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dut_done[0]) begin
        n_done++;
        bcd = dut_bcd[0];
      end
    end
    chk("busy_reject.dones", 64'(n_done), 64'd1);
    chk("busy_reject.bcd", 64'(bcd), 64'h042);

    // Back-to-back with start held high.
    drv_start[0] = 1'b1;
    drv_bin[0]   = 32'd17;
    gap = 0;
    do begin tick(); gap++; end while (!dut_done[0] && gap < 64);
    chk("b2b.first_edges", 64'(gap), 64'd9);
    chk("b2b.first_bcd", 64'(dut_bcd[0]), 64'h017);
    drv_bin[0] = 32'd250;
    gap = 0;
    do begin tick(); gap++; end while (!dut_done[0] && gap < 64);
    drv_start[0] = 1'b0;
    chk("b2b.gap", 64'(gap), 64'd9);
    chk("b2b.second_bcd", 64'(dut_bcd[0]), 64'h250);
    tick();

    // Asynchronous reset in the middle of a conversion.
    drv_start[0] = 1'b1;
    drv_bin[0]   = 32'd123;
    tick();
    drv_start[0] = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.busy", 64'(dut_busy[0]), 64'd0);
    chk("midreset.done", 64'(dut_done[0]), 64'd0);
    chk("midreset.bcd", 64'(dut_bcd[0]), 64'd0);
    chk("midreset.ovf", 64'(dut_ovf[0]), 64'd0);
    chk("midreset.lz", 64'(dut_lz[0]), 64'b110);
    tick();
    #3;
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (dut_done[0]) n_done++;
    end
    chk("midreset.no_done", 64'(n_done), 64'd0);
    run_conv(0, 32'd5, lat, bcd, ovf, lz);
    chk("midreset.after_bcd", 64'(bcd), 64'h005);
    chk("midreset.after_latency", 64'(lat), 64'd8);

    // Random traffic on all instances, checked by the model every cycle.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        drv_start[i] = ($urandom_range(0, 3) != 0);
        drv_bin[i]   = $urandom;
      end
      tick();
    end
    for (int i = 0; i < 4; i++) drv_start[i] = 1'b0;
    for (int c = 0; c < 40; c++) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It converts an unsigned WIDTH-bit value into DIGITS packed BCD digits, with overflow and leading-zero flags, over a start/busy/done handshake. It sits between score, timer and counter registers and the seven-segment/text display drivers. It is the general-width successor to the 8-bit two-digit combinational converter.

## Interface
- WIDTH, 8: binary input width, 1..32
- DIGITS, 3: number of BCD output digits, 1..10
- clk_in  input  1  system clock, all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  request conversion; sampled only when busy_out = 0
- bin_in  input  WIDTH  unsigned value; captured on the accepting edge
- busy_out  output  1  conversion in progress
- done_out  output  1  one-cycle pulse: results just updated
- bcd_out  output  4*DIGITS  digit i in bits [4i+3:4i], digit 0 = ones; held between conversions
- overflow_out  output  1  captured value ≥ 10^DIGITS; held with bcd_out
- lz_out  output  DIGITS  bit i = 1 iff digit i and all higher digits are zero; bit 0 always 0

## Operation
- FSM states: IDLE, SHIFT. Reset → IDLE.
- IDLE: if start_in = 1, capture bin_in into the shift register, clear the BCD scratch register, load the bit counter with WIDTH, compute overflow from the captured value, and go to SHIFT. Otherwise hold.
- SHIFT: each cycle, add 3 to every scratch digit ≥ 5, then shift {scratch, shift} left by 1 with the binary MSB entering scratch bit 0. Then decrement the counter.
  - After the WIDTH-th shift: load bcd_out, overflow_out and lz_out from the final scratch value, pulse done_out, and return to IDLE.
- Bits shifted out of the top digit are discarded. On overflow, bcd_out = value mod 10^DIGITS.
- The overflow comparison uses a constant 10^DIGITS sized to max(WIDTH, ceil(log2(10^DIGITS))+1) bits. There is no truncation in the compare.
- start_in while busy_out = 1 is ignored; no queueing.
- bin_in is don't-care except on the accepting edge.
- bcd_out, overflow_out and lz_out change only on the done edge. Intermediate scratch values are never visible.
- lz_out is registered from the final digits, so bit i = 1 iff digits DIGITS-1..i are all zero, for i ≥ 1.

## Timing
- Reset (asynchronous assert, any cycle including mid-conversion):
  - busy_out = 0, done_out = 0, bcd_out = 0, overflow_out = 0
  - lz_out = all ones except bit 0 = 0
  - FSM = IDLE; any in-flight conversion is discarded, with no done pulse.
- Accept at edge E0 (start_in = 1, IDLE). busy_out is 1 from E0 to E_WIDTH.
- At edge E_WIDTH: outputs update, done_out = 1 for exactly one cycle, busy_out = 0.
- Latency is WIDTH cycles from the accepting edge to the result.
- Back-to-back: start_in high during the done cycle is accepted at E_WIDTH+1. Throughput is one conversion per WIDTH+1 cycles.
- Holding start_in continuously produces repeated conversions, each re-capturing bin_in.
- No combinational path from any input to any output.

## Test plan
- WIDTH=8, DIGITS=3. Sweep bin_in = 0..255.
  - Each conversion: done_out pulses once, exactly 8 cycles after accept.
  - bcd_out equals the decimal digits, e.g. 9 → 0x009, 10 → 0x010, 79 → 0x079, 80 → 0x080, 81 → 0x081, 255 → 0x255.
  - overflow_out = 0 throughout.
  - lz_out: 0 → 3'b110, 9 → 3'b110, 10 → 3'b100, 100 → 3'b000.
- WIDTH=8, DIGITS=2:
  - 99 → 0x99, overflow 0.
  - 100 → 0x00, overflow 1, lz_out 2'b10.
  - 255 → 0x55, overflow 1.
- Busy rejection: accept 42, then pulse start_in with 200 at cycles 1..7.
  - Single done with 0x042; no second conversion.
- Back-to-back: start_in held high with bin_in 17, then 250 presented in the done cycle.
  - Done pulses 9 cycles apart; results 0x017 then 0x250.
- Reset mid-operation: accept 123, assert rst_n_in low at cycle 4 (asynchronously, between edges).
  - Outputs go to reset values immediately; no done pulse.
  - After release, accept 5 → 0x005.
- WIDTH=16, DIGITS=5: 65535 → 0x65535 after 16 cycles, overflow 0.
- WIDTH=1, DIGITS=1: 1 → 0x1 after 1 cycle.
